dsp_wd_monitor: RTL
===================

// Module: dsp_wd_monitor
// PURPOSE
//  Hardware watchdog for the DSP. It sits directly upstream of the XINT/DSP fault checker
//  and drives that checker's watchdog-error input (o_WD_DSP_ERR).
//  The DSP feeds the watchdog in either of two ways:
//   - toggling pin WDI;
//   - writing the kick address on the XINTF bus (XZCS6 low, XWE low).
//  On a missed feed the block pulses a DSP reset, then holds off during the DSP reboot.
//  After P_ERR_MAX consecutive trips it latches a fatal fault.
// PARAMETERS
//  P_PRESC    100      clk_20M cycles per tick (tick = 5us)
//  P_TIMEOUT  400      feed timeout in ticks (2ms)
//  P_RST_LEN  200      DSP reset pulse length in ticks (1ms)
//  P_BOOT     20000    post-reset / post-power-up holdoff in ticks (100ms)
//  P_KICK     16'h03C3 XINTF kick address
//  P_ERR_MAX  3        consecutive trips before fatal latch (1..255)
// PORTS
//  clk_20M       in   1   system clock, 20MHz
//  reset         in   1   one clock; reset is synchronous and active-high
//  XZCS6         in   1   DSP zone-6 chip select, active low
//  XWE           in   1   DSP write enable, active low
//  DSP_A         in   16  DSP address bus
//  WDI           in   1   DSP watchdog toggle pin, asynchronous
//  fatal_clr     in   1   one-cycle pulse; clears fatal latch and trip counter
//  o_WD_DSP_ERR  out  1   watchdog error; to the fault checker's i_WD_DSP_ERR
//  WD_DSP_RST    out  1   DSP reset request, active high
//  wd_fatal      out  1   latched fatal fault
//  wd_state      out  2   FSM state: 0=BOOT 1=RUN 2=RST 3=HOLD
//  wd_trip_cnt   out  8   consecutive trip count, saturates at 255
// BEHAVIOUR
//  Reset
//   - All outputs and counters go to 0 and the FSM goes to BOOT.
//   - Reset mid-operation aborts any reset pulse immediately: WD_DSP_RST=0 on the next cycle.
//  Feed event (feed)
//   - WDI passes through a 2-FF synchronizer; any edge (rise or fall) gives a 1-cycle pulse.
//     feed asserts 3 cycles after the pin edge.
//   - kick_q is the registered value of (XZCS6==0 && XWE==0 && DSP_A==P_KICK).
//     A rising edge of kick_q gives a 1-cycle pulse, 2 cycles after the strobe.
//     A held strobe counts once.
//   - Pin and bus events in the same cycle make a single feed.
//  Tick
//   - presc counts 0..P_PRESC-1 and wraps; tick=1 when presc==P_PRESC-1.
//   - presc and tcnt (16b) clear on every state entry.
//  FSM
//   - BOOT: feed is ignored. tcnt counts ticks. At tick with tcnt==P_BOOT-1 -> RUN.
//   - RUN: feed clears presc and tcnt to 0 and clears wd_trip_cnt.
//     At tick with tcnt==P_TIMEOUT-1 and no feed in that cycle -> RST, and wd_trip_cnt++.
//     A feed arriving in the same cycle as the timeout tick wins; the state stays RUN.
//   - RST: WD_DSP_RST=1 for exactly P_RST_LEN*P_PRESC cycles, then -> HOLD.
//   - HOLD: feed is ignored. At tick with tcnt==P_BOOT-1 -> RUN.
//     If wd_fatal=1, HOLD is terminal and no further reset pulses are issued.
//  Outputs
//   - o_WD_DSP_ERR = 1 in RST and HOLD, or whenever wd_fatal=1. Registered.
//   - WD_DSP_RST = 1 only in RST. Registered.
//  Fatal latch and fatal_clr
//   - wd_fatal sets on the cycle wd_trip_cnt becomes >=P_ERR_MAX.
//   - fatal_clr clears wd_fatal and wd_trip_cnt.
//     If the FSM is in terminal HOLD, it moves to BOOT on the next cycle.
//     fatal_clr has priority over a coincident trip.
//  Widths
//   - The tick counter must hold P_BOOT-1 (16b).
//   - wd_trip_cnt saturates at 255 and does not wrap.
// TESTING (bench params P_PRESC=4 P_TIMEOUT=10 P_RST_LEN=5 P_BOOT=20 P_ERR_MAX=3)
//  1. Boot: release reset, no feed.
//     -> wd_state=BOOT for 80 cycles, then RUN. o_WD_DSP_ERR stays 0.
//  2. Healthy: toggle WDI every 30 cycles for 1000 cycles.
//     -> stays in RUN, WD_DSP_RST=0, wd_trip_cnt=0.
//     Repeat with bus writes to 16'h03C3 only: same result.
//  3. Timeout: stop feeding in RUN.
//     -> RST entered 40 cycles after the last feed.
//     -> WD_DSP_RST high exactly 20 cycles, then HOLD for 80 cycles, then RUN.
//     -> o_WD_DSP_ERR high for 100 cycles; wd_trip_cnt=1.
//  4. Race: feed lands on the exact timeout-tick cycle.
//     -> no trip; tcnt=0; state stays RUN.
//     Same strobe held 10 cycles -> counted as one feed.
//  5. Fatal: 3 consecutive trips.
//     -> wd_fatal=1, FSM stuck in HOLD, o_WD_DSP_ERR=1, no 4th reset pulse.
//     Pulse fatal_clr -> BOOT next cycle, wd_fatal=0, wd_trip_cnt=0.
//  6. Reset during RST: assert reset 5 cycles into the pulse.
//     -> WD_DSP_RST=0 and state=BOOT on the next cycle; all outputs 0.

Source files
------------

// File: rtl/dsp_wd_monitor_if.sv
// DSP-side watchdog feed signals: XINTF zone-6 strobe, address bus and WDI toggle pin.
// Pure wiring, no latency; no backpressure (the DSP drives these unconditionally).
// master = DSP / bench side, slave = watchdog side.
interface dsp_wd_monitor_if;
  logic        XZCS6;
  logic        XWE;
  logic [15:0] DSP_A;
  logic        WDI;

  modport master (output XZCS6, output XWE, output DSP_A, output WDI);
  modport slave  (input  XZCS6, input  XWE, input  DSP_A, input  WDI);
endinterface

// File: rtl/dsp_wd_monitor.sv
// DSP hardware watchdog: feed via WDI toggle or XINTF kick write; trips reset the DSP, repeated trips latch fatal.
// Latency: pin edge -> feed 3 cycles, bus strobe -> feed 2 cycles; outputs registered, aligned with wd_state.
// No backpressure: all inputs are sampled every cycle; a held kick strobe counts once.
module dsp_wd_monitor #(
  parameter int unsigned P_PRESC   = 100,
  parameter int unsigned P_TIMEOUT = 400,
  parameter int unsigned P_RST_LEN = 200,
  parameter int unsigned P_BOOT    = 20000,
  parameter logic [15:0] P_KICK    = 16'h03C3,
  parameter int unsigned P_ERR_MAX = 3
) (
  input  logic                    clk_20M,
  input  logic                    reset,
  dsp_wd_monitor_if.slave         bus,
  input  logic                    fatal_clr,
  output logic                    o_WD_DSP_ERR,
  output logic                    WD_DSP_RST,
  output logic                    wd_fatal,
  output logic [1:0]              wd_state,
  output logic [7:0]              wd_trip_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RST  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [15:0] PRESC_LAST   = 16'(P_PRESC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(P_TIMEOUT - 1);
  localparam logic [15:0] RSTLEN_LAST  = 16'(P_RST_LEN - 1);
  localparam logic [15:0] BOOT_LAST    = 16'(P_BOOT - 1);
  localparam logic [7:0]  ERR_MAX      = 8'(P_ERR_MAX);

  // Feed path registers
  logic       wdi_s1_q, wdi_s2_q, wdi_prev_q;
  logic       kick_q, kick_prev_q;
  logic       feed_q;
  logic       kick_hit, feed_d;

  // FSM and counters
  logic [1:0]  state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [7:0]  trip_q, trip_d;
  logic [7:0]  trip_inc;
  logic        fatal_q, fatal_d;
  logic        err_q, err_d;
  logic        rst_out_q, rst_out_d;
  logic        tick;

  assign kick_hit = !bus.XZCS6 && !bus.XWE && (bus.DSP_A == P_KICK);
  // Either pin edge or kick rising edge; both together still make one pulse.
  assign feed_d   = (wdi_s2_q ^ wdi_prev_q) | (kick_q & ~kick_prev_q);

  // Synchronise WDI, register the kick decode, and form the single-cycle feed pulse.
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      wdi_s1_q    <= 1'b0;
      wdi_s2_q    <= 1'b0;
      wdi_prev_q  <= 1'b0;
      kick_q      <= 1'b0;
      kick_prev_q <= 1'b0;
      feed_q      <= 1'b0;
    end else begin
      wdi_s1_q    <= bus.WDI;
      wdi_s2_q    <= wdi_s1_q;
      wdi_prev_q  <= wdi_s2_q;
      kick_q      <= kick_hit;
      kick_prev_q <= kick_q;
      feed_q      <= feed_d;
    end
  end

  assign tick     = (presc_q == PRESC_LAST);
  assign trip_inc = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;

  // Next-state logic for the FSM, prescaler, tick counter, trip counter and fatal latch.
  always_comb begin
    state_d = state_q;
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    tcnt_d  = tick ? tcnt_q + 16'd1 : tcnt_q;
    trip_d  = trip_q;
    fatal_d = fatal_q;

    case (state_q)
      ST_BOOT: begin
        if (tick && tcnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A feed on the timeout tick wins over the trip.
        if (feed_q) begin
          presc_d = 16'd0;
          tcnt_d  = 16'd0;
          trip_d  = 8'd0;
        end else if (tick && tcnt_q == TIMEOUT_LAST) begin
          state_d = ST_RST;
          trip_d  = trip_inc;
          if (trip_inc >= ERR_MAX) fatal_d = 1'b1;
        end
      end
      ST_RST: begin
        if (tick && tcnt_q == RSTLEN_LAST) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Terminal while fatal: freeze the counters so no reboot is ever attempted.
        if (fatal_q) begin
          presc_d = presc_q;
          tcnt_d  = tcnt_q;
        end else if (tick && tcnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Operator clear beats a coincident trip and releases a terminal HOLD.
    if (fatal_clr) begin
      fatal_d = 1'b0;
      trip_d  = 8'd0;
      if (state_q == ST_HOLD && fatal_q) state_d = ST_BOOT;
    end

    // Every state entry starts timing from a clean tick boundary.
    if (state_d != state_q) begin
      presc_d = 16'd0;
      tcnt_d  = 16'd0;
    end
  end

  // Outputs are registered from next-state so they line up with wd_state.
  always_comb begin
    err_d     = (state_d == ST_RST) || (state_d == ST_HOLD) || fatal_d;
    rst_out_d = (state_d == ST_RST);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      presc_q   <= 16'd0;
      tcnt_q    <= 16'd0;
      trip_q    <= 8'd0;
      fatal_q   <= 1'b0;
      err_q     <= 1'b0;
      rst_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      trip_q    <= trip_d;
      fatal_q   <= fatal_d;
      err_q     <= err_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign o_WD_DSP_ERR = err_q;
  assign WD_DSP_RST   = rst_out_q;
  assign wd_fatal     = fatal_q;
  assign wd_state     = state_q;
  assign wd_trip_cnt  = trip_q;

endmodule
